serial_subtractor_4bit_fsm: RTL

//  Bit-serial N-bit subtractor with start/done handshake: computes
//  {Bout,Diff} = A - B - Bin, LSB first, one bit per clock.

---
 rtl/serial_subtractor_4bit_fsm.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor_4bit_fsm.sv
// Bit-serial subtractor: {Bout,Diff} = A - B - Bin, one bit per clock, LSB first.
// The result is registered at the end of the run and held until the next one completes.
module serial_subtractor_4bit_fsm #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic [N-1:0] Diff,
  output logic         Bout,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           r_br;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_acc;
  logic [N-1:0]   r_diff;
  logic           r_bout;
  logic           r_busy;
  logic           r_done;

  state_t         w_state_nxt;
  logic [N-1:0]   w_a_nxt;
  logic [N-1:0]   w_b_nxt;
  logic           w_br_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [N-1:0]   w_acc_nxt;
  logic [N-1:0]   w_diff_nxt;
  logic           w_bout_nxt;
  logic           w_busy_nxt;
  logic           w_done_nxt;

  logic           w_d;
  logic           w_br_step;
  logic [N-1:0]   w_acc_shift;
  logic           w_last;

  // One full-subtractor bit step on the current LSBs and borrow.
  always_comb begin
    w_d         = r_a[0] ^ r_b[0] ^ r_br;
    w_br_step   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    w_acc_shift = {w_d, r_acc[N-1:1]};
    w_last      = (r_cnt == CW'(N - 1));
  end

  // Next-state and next-register values for the FSM and datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_br_nxt    = r_br;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_diff_nxt  = r_diff;
    w_bout_nxt  = r_bout;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_a_nxt     = A;
          w_b_nxt     = B;
          w_br_nxt    = Bin;
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        w_a_nxt   = r_a >> 1;
        w_b_nxt   = r_b >> 1;
        w_br_nxt  = w_br_step;
        w_acc_nxt = w_acc_shift;
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_diff_nxt  = w_acc_shift;
          w_bout_nxt  = w_br_step;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_br    <= w_br_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_diff  <= w_diff_nxt;
      r_bout  <= w_bout_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign Diff = r_diff;
  assign Bout = r_bout;
  assign busy = r_busy;
  assign done = r_done;

endmodule
